wave_capture: RTL

Capture stage that feeds `wave_display`. It watches the audio sample stream, arms on a positive-going zero crossing, and writes 256 consecutive samples into the half of the double-buffered waveform RAM that the display is not reading. Once the display reports it is idle (blanking), it flips `read_index` so the new waveform is shown tear-free. It sits between the codec/sample pipeline and the waveform RAM; `wave_display` owns the RAM read port.

---
 rtl/wave_capture.sv | 108 ++++++++++
 1 files changed

// File: rtl/wave_capture.sv
// wave_capture
// Watches the audio sample stream, arms on a positive-going zero crossing and
// writes 256 consecutive converted samples into the waveform RAM half that the
// display is not reading. When the display reports idle, read_index flips so
// the new capture is shown without tearing.
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous, active-high reset
//   new_sample_ready   in   one-cycle strobe, new_sample_in valid
//   new_sample_in      in   16-bit signed audio sample
//   wave_display_idle  in   display not drawing; buffer swap is safe
//   write_address      out  RAM write address {~read_index, count}
//   write_enable       out  RAM write strobe, one cycle per captured sample
//   write_sample       out  RAM write data (display-oriented 8-bit value)
//   read_index         out  buffer half currently shown by the display
//
// state   | meaning
// ARMED   | waiting for a negative -> non-negative sample pair
// ACTIVE  | writing 256 samples into the hidden half
// WAIT    | capture complete, waiting for display idle to swap halves

module wave_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_prev_sample;
    logic [7:0]  r_count;
    logic        r_read_index;
    logic [8:0]  r_write_address;
    logic        r_write_enable;
    logic [7:0]  r_write_sample;

    logic        w_crossing;
    logic [7:0]  w_conv;

    assign w_crossing = r_prev_sample[15] & ~new_sample_in[15];
    // 127 - s[15:8] mod 256: positive peaks map to small values (top of screen)
    assign w_conv     = {new_sample_in[15], ~new_sample_in[14:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_ARMED;
            r_prev_sample   <= 16'd0;
            r_count         <= 8'd0;
            r_read_index    <= 1'b0;
            r_write_address <= 9'd0;
            r_write_enable  <= 1'b0;
            r_write_sample  <= 8'd0;
        end else begin
            r_write_enable <= 1'b0;
            if (new_sample_ready) begin
                r_prev_sample <= new_sample_in;
            end
            case (r_state)
                ST_ARMED: begin
                    // The crossing sample itself is not written
                    if (new_sample_ready && w_crossing) begin
                        r_state <= ST_ACTIVE;
                        r_count <= 8'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (new_sample_ready) begin
                        r_write_enable  <= 1'b1;
                        r_write_address <= {~r_read_index, r_count};
                        r_write_sample  <= w_conv;
                        r_count         <= r_count + 8'd1;
                        if (r_count == 8'd255) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A strobe on the swap edge is a WAIT strobe: no crossing check
                    if (wave_display_idle) begin
                        r_read_index <= ~r_read_index;
                        r_state      <= ST_ARMED;
                    end
                end
                default: begin
                    r_state <= ST_ARMED;
                end
            endcase
        end
    end

    assign write_address = r_write_address;
    assign write_enable  = r_write_enable;
    assign write_sample  = r_write_sample;
    assign read_index    = r_read_index;

endmodule
